// File: rtl/axi4_ram.sv
// axi4_ram: single-port AXI4 slave RAM, one transaction in flight, round-robin AW/AR grant.
// Reads take a registered RAM cycle per beat; writes honour byte strobes.
module axi4_ram #(
    parameter int ARCHBITSZ     = 32,
    parameter int AXI4_ID_WIDTH = 4,
    parameter int DEPTH         = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [AXI4_ID_WIDTH-1:0] axi4_awid_i,
    input  logic [ARCHBITSZ-1:0]     axi4_awaddr_i,
    input  logic [7:0]               axi4_awlen_i,
    input  logic [2:0]               axi4_awsize_i,
    input  logic [1:0]               axi4_awburst_i,
    input  logic                     axi4_awlock_i,
    input  logic [3:0]               axi4_awcache_i,
    input  logic [2:0]               axi4_awprot_i,
    input  logic [3:0]               axi4_awqos_i,
    input  logic                     axi4_awvalid_i,
    output logic                     axi4_awready_o,
    input  logic [ARCHBITSZ-1:0]     axi4_wdata_i,
    input  logic [ARCHBITSZ/8-1:0]   axi4_wstrb_i,
    input  logic                     axi4_wlast_i,
    input  logic                     axi4_wvalid_i,
    output logic                     axi4_wready_o,
    output logic [AXI4_ID_WIDTH-1:0] axi4_bid_o,
    output logic [1:0]               axi4_bresp_o,
    output logic                     axi4_bvalid_o,
    input  logic                     axi4_bready_i,
    input  logic [AXI4_ID_WIDTH-1:0] axi4_arid_i,
    input  logic [ARCHBITSZ-1:0]     axi4_araddr_i,
    input  logic [7:0]               axi4_arlen_i,
    input  logic [2:0]               axi4_arsize_i,
    input  logic [1:0]               axi4_arburst_i,
    input  logic                     axi4_arlock_i,
    input  logic [3:0]               axi4_arcache_i,
    input  logic [2:0]               axi4_arprot_i,
    input  logic [3:0]               axi4_arqos_i,
    input  logic                     axi4_arvalid_i,
    output logic                     axi4_arready_o,
    output logic [AXI4_ID_WIDTH-1:0] axi4_rid_o,
    output logic [ARCHBITSZ-1:0]     axi4_rdata_o,
    output logic [1:0]               axi4_rresp_o,
    output logic                     axi4_rlast_o,
    output logic                     axi4_rvalid_o,
    input  logic                     axi4_rready_i
);
    localparam int NB  = ARCHBITSZ / 8;
    localparam int OFF = $clog2(NB);
    localparam int AW  = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, WDATA, WRESP, RREAD, RDATA} state_t;

    state_t                   state, state_nx;
    logic [ARCHBITSZ-1:0]     mem [DEPTH];
    logic [ARCHBITSZ-1:0]     rdata;
    logic [AXI4_ID_WIDTH-1:0] id;
    logic [AW-1:0]            idx, idx_nx;
    logic [1:0]               burst;
    logic [7:0]               cnt;
    logic                     err, last_wr, last;
    logic                     aw_hs, ar_hs, w_hs, r_hs;
    logic                     unused;

    assign unused = ^{axi4_awaddr_i, axi4_awsize_i, axi4_awlock_i, axi4_awcache_i, axi4_awprot_i,
                      axi4_awqos_i, axi4_araddr_i, axi4_arsize_i, axi4_arlock_i, axi4_arcache_i,
                      axi4_arprot_i, axi4_arqos_i};

    // last_wr remembers the previous grant so simultaneous requests alternate
    assign axi4_awready_o = rst_i && state == IDLE && (!axi4_arvalid_i || !last_wr);
    assign axi4_arready_o = rst_i && state == IDLE && (!axi4_awvalid_i || last_wr);
    assign aw_hs  = axi4_awvalid_i && axi4_awready_o;
    assign ar_hs  = axi4_arvalid_i && axi4_arready_o;
    assign w_hs   = state == WDATA && axi4_wvalid_i;
    assign r_hs   = state == RDATA && axi4_rready_i;
    assign last   = cnt == 8'd0;
    assign idx_nx = burst == 2'b00 ? idx : idx + 1'b1;

    assign axi4_wready_o = state == WDATA;
    assign axi4_bvalid_o = state == WRESP;
    assign axi4_bid_o    = id;
    assign axi4_bresp_o  = (state == WRESP && err) ? 2'b10 : 2'b00;
    assign axi4_rvalid_o = state == RDATA;
    assign axi4_rid_o    = id;
    assign axi4_rdata_o  = rdata;
    assign axi4_rresp_o  = 2'b00;
    assign axi4_rlast_o  = state == RDATA && last;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = aw_hs ? WDATA : ar_hs ? RREAD : IDLE;
            WDATA:   state_nx = (w_hs && last) ? WRESP : WDATA;
            WRESP:   state_nx = axi4_bready_i ? IDLE : WRESP;
            RREAD:   state_nx = RDATA;
            RDATA:   state_nx = r_hs ? (last ? IDLE : RREAD) : RDATA;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            id      <= '0;
            idx     <= '0;
            burst   <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            last_wr <= 1'b0;
            rdata   <= '0;
        end else begin
            if (aw_hs) begin
                id      <= axi4_awid_i;
                idx     <= axi4_awaddr_i[OFF +: AW];
                burst   <= axi4_awburst_i;
                cnt     <= axi4_awlen_i;
                err     <= 1'b0;
                last_wr <= 1'b1;
            end else if (ar_hs) begin
                id      <= axi4_arid_i;
                idx     <= axi4_araddr_i[OFF +: AW];
                burst   <= axi4_arburst_i;
                cnt     <= axi4_arlen_i;
                last_wr <= 1'b0;
            end
            if (w_hs && axi4_wlast_i != last) err <= 1'b1;
            if ((w_hs || r_hs) && !last) begin
                cnt <= cnt - 8'd1;
                idx <= idx_nx;
            end
            if (state == RREAD) rdata <= mem[idx];
        end
    end

    // storage is deliberately outside the reset domain
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++)
            if (w_hs && axi4_wstrb_i[b]) mem[idx][8*b +: 8] <= axi4_wdata_i[8*b +: 8];
    end
endmodule

// File: doc/axi4_ram.md
AXI4_RAM -- requirements
Module: axi4_ram

Interface
REQ-001 SHALL have parameter ARCHBITSZ, default 32, meaning data-bus width in bits (16/32/64/128/256).
REQ-002 SHALL have parameter AXI4_ID_WIDTH, default 4, meaning width of all ID fields.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning RAM size in ARCHBITSZ-wide words (power of 2).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk_i  input  1  clock; all state updates on rising edge.
REQ-006 rst_i  input  1  asynchronous, active-low reset.
REQ-007 axi4_awid_i/awaddr_i/awlen_i/awsize_i/awburst_i  input  AXI4_ID_WIDTH/ARCHBITSZ/8/3/2  write address; lock/cache/prot/qos inputs accepted and ignored.
REQ-008 axi4_awvalid_i  input  1; axi4_awready_o  output  1.
REQ-009 axi4_wdata_i  input  ARCHBITSZ; axi4_wstrb_i  input  ARCHBITSZ/8; axi4_wlast_i, axi4_wvalid_i  input  1; axi4_wready_o  output  1.
REQ-010 axi4_bid_o  output  AXI4_ID_WIDTH; axi4_bresp_o  output  2; axi4_bvalid_o  output  1; axi4_bready_i  input  1.
REQ-011 axi4_arid_i/araddr_i/arlen_i/arsize_i/arburst_i  input  as AW; axi4_arvalid_i  input  1; axi4_arready_o  output  1.
REQ-012 axi4_rid_o  output  AXI4_ID_WIDTH; axi4_rdata_o  output  ARCHBITSZ; axi4_rresp_o  output  2; axi4_rlast_o, axi4_rvalid_o  output  1; axi4_rready_i  input  1.

Function
REQ-013 Word index SHALL be addr[clog2(ARCHBITSZ/8) +: clog2(DEPTH)]; upper address bits ignored (aliasing, no error).
REQ-014 awsize/arsize SHALL be ignored; every beat is one full word; burst types FIXED (00) hold index, INCR (01) and WRAP (10) increment index modulo DEPTH.
REQ-015 FSM states SHALL be IDLE, WDATA, WRESP, RREAD, RDATA.
REQ-016 IDLE: awready_o = !arvalid_i || lastgnt==RD; arready_o = !awvalid_i || lastgnt==WR; both arriving together SHALL be granted round-robin via lastgnt.
REQ-017 AW handshake SHALL latch id, index, burst, count=awlen, clear err, set lastgnt=WR, go WDATA.
REQ-018 WDATA: wready_o=1; each wvalid beat writes bytes selected by wstrb to RAM[index]; unselected bytes unchanged.
REQ-019 Burst SHALL end on beat where count==0; if wlast_i disagrees with count==0 on any beat, err SHALL set; count decrements, index advances per REQ-014 otherwise.
REQ-020 After final beat SHALL go WRESP: bvalid_o=1, bid_o=latched id, bresp_o=err?2'b10:2'b00; on bready_i go IDLE.
REQ-021 AR handshake SHALL latch id, index, burst, count=arlen, set lastgnt=RD, go RREAD.
REQ-022 RREAD: synchronous RAM read of index issued; next cycle RDATA.
REQ-023 RDATA: rvalid_o=1, rdata_o=RAM word, rid_o=latched id, rresp_o=00, rlast_o=(count==0); outputs stable until rready_i.
REQ-024 On rready_i in RDATA: if count==0 go IDLE, else decrement count, advance index, go RREAD.
REQ-025 Latency: AR handshake cycle N -> first rvalid_o at N+2; sustained read one beat per 2 cycles; AW handshake N -> wready_o at N+1; bvalid_o cycle after last W beat.
REQ-026 awready_o/arready_o SHALL be 0 outside IDLE; wready_o only in WDATA; bvalid_o only in WRESP; rvalid_o only in RDATA.
REQ-027 Only one transaction SHALL be in flight; no read/write overlap.

Reset
REQ-028 rst_i low SHALL immediately force IDLE, lastgnt=RD, all valid/ready outputs 0 except IDLE-derived awready_o/arready_o after release, bid/rid/bresp/rresp/rdata/rlast 0.
REQ-029 Reset mid-burst SHALL abort transaction without response; RAM contents are not reset.

Verification
REQ-030 Write awaddr=0x10, awlen=0, wdata=0xDEADBEEF, wstrb=0xF -> bresp=00; read araddr=0x10 -> rdata=0xDEADBEEF, rlast=1, rvalid 2 cycles after AR.
REQ-031 INCR write awlen=3 at 0x0 data 1..4, then wstrb=0x1 write 0xFF to 0x4 -> 4-beat read returns 1, 0x000000FF? no: 0x000000FF|(2&~0xFF)=0xFF, 3, 4; rlast only beat 4.
REQ-032 awvalid and arvalid same cycle after reset -> write granted first; repeated simultaneous requests alternate W,R,W.
REQ-033 awlen=1 with wlast=1 on first beat -> two beats still consumed, bresp=2'b10.
REQ-034 rready held low 5 cycles in RDATA -> rvalid, rdata, rlast stable throughout; FIXED burst arlen=2 returns same word 3 times.
REQ-035 rst_i low during beat 2 of 4-beat read -> rvalid_o 0 same cycle; after release new AR accepted, earlier RAM writes intact.
